// File: rtl/mem_resp_if.sv
// Handshake bundle between EX/WB/data bus and the MEM-stage response queue.
`timescale 1ns/1ps
interface mem_resp_if #(
   parameter int DATA_W = 32
);
   localparam int OFF_W = $clog2(DATA_W / 8);

   logic              req_push;
   logic [2:0]        req_op;
   logic              req_store;
   logic [OFF_W-1:0]  req_off;
   logic              req_full;
   logic              data_ok;
   logic [DATA_W-1:0] rdata;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_store;
   logic              resp_err;

   modport slave (
      input  req_push, req_op, req_store, req_off, data_ok, rdata, flush, out_ready,
      output req_full, out_valid, out_data, out_store, resp_err
   );

   modport master (
      output req_push, req_op, req_store, req_off, data_ok, rdata, flush, out_ready,
      input  req_full, out_valid, out_data, out_store, resp_err
   );
endinterface

// File: rtl/mem_resp_queue.sv
// MEM-stage tracker: pairs in-order data_ok responses with outstanding requests, holds results for WB.
// Optional MS_BYPASS_EN adds a same-cycle rdata->out_data path for a lone pending head entry.
`timescale 1ns/1ps
module mem_resp_queue #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input logic       clk,
   input logic       reset,
   mem_resp_if.slave q
);
   localparam int OFF_W = $clog2(DATA_W / 8);
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = PW + 1;

   logic [2:0]        ent_op      [DEPTH];
   logic [OFF_W-1:0]  ent_off     [DEPTH];
   logic [DATA_W-1:0] ent_data_p1 [DEPTH];
   logic [DEPTH-1:0]  ent_store;
   logic [DEPTH-1:0]  ent_done_p1;

   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] cnt, pend_cnt, drop_cnt;
   logic          err_q;

   logic              full, push_ok, head_done;
   logic              dok_drop, dok_fill, dok_bad;
   logic              byp_hit, byp_pop, out_valid, pop;
   logic [PW-1:0]     fill_idx;
   logic [DATA_W-1:0] ext_p0, fill_val_p0, out_data;

   function automatic logic [DATA_W-1:0] extract(input logic [2:0]        op,
                                                 input logic [OFF_W-1:0]  off,
                                                 input logic [DATA_W-1:0] rdata);
      logic [DATA_W-1:0] lane;
      logic signed [7:0]  sb;
      logic signed [15:0] sh;
      logic signed [31:0] sw;
      lane = rdata >> {off, 3'b000};
      sb   = lane[7:0];
      sh   = lane[15:0];
      sw   = lane[31:0];
      case (op)
         3'b000:  extract = DATA_W'(sb);
         3'b001:  extract = DATA_W'(sh);
         3'b010:  extract = DATA_W'(sw);
         3'b100:  extract = DATA_W'(lane[7:0]);
         3'b101:  extract = DATA_W'(lane[15:0]);
         3'b110:  extract = DATA_W'(lane[31:0]);
         default: extract = rdata;
      endcase
   endfunction

   // Stage p0: classify the response and extract the lane for the oldest pending entry
   assign full      = (cnt + drop_cnt) == CW'(DEPTH);
   assign push_ok   = q.req_push && !full;
   assign head_done = ent_done_p1[rd_ptr];
   assign fill_idx  = rd_ptr + PW'(cnt - pend_cnt);
   assign ext_p0    = extract(ent_op[fill_idx], ent_off[fill_idx], q.rdata);
   assign fill_val_p0 = ent_store[fill_idx] ? '0 : ext_p0;

   assign dok_drop = q.data_ok && (drop_cnt != '0);
   assign dok_fill = q.data_ok && (drop_cnt == '0) && (pend_cnt != '0);
   assign dok_bad  = q.data_ok && (drop_cnt == '0) && (pend_cnt == '0);

`ifdef MS_BYPASS_EN
   assign byp_hit = !q.flush && dok_fill && (cnt == CW'(1));
`else
   assign byp_hit = 1'b0;
`endif

   assign out_valid = !q.flush && (head_done || byp_hit);
   assign pop       = out_valid && q.out_ready;
   assign byp_pop   = byp_hit && q.out_ready;

   always_comb begin
      out_data = '0;
      if (out_valid)
         out_data = head_done ? ent_data_p1[rd_ptr] : fill_val_p0;
   end

   assign q.req_full  = full;
   assign q.out_valid = out_valid;
   assign q.out_data  = out_data;
   assign q.out_store = out_valid && ent_store[rd_ptr];
   assign q.resp_err  = err_q;

   // Stage p1: queue control and completion flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         cnt         <= '0;
         pend_cnt    <= '0;
         drop_cnt    <= '0;
         ent_done_p1 <= '0;
         err_q       <= 1'b0;
      end else if (q.flush) begin
         // Every still-outstanding bus transaction becomes a drop; a same-cycle response eats one
         rd_ptr      <= wr_ptr;
         cnt         <= '0;
         pend_cnt    <= '0;
         ent_done_p1 <= '0;
         drop_cnt    <= drop_cnt + pend_cnt + CW'(push_ok)
                        - CW'(q.data_ok && ((drop_cnt != '0) || (pend_cnt != '0)));
         if (dok_bad)
            err_q <= 1'b1;
      end else begin
         if (push_ok) begin
            ent_done_p1[wr_ptr] <= 1'b0;
            wr_ptr              <= wr_ptr + PW'(1);
         end
         if (dok_fill && !byp_pop)
            ent_done_p1[fill_idx] <= 1'b1;
         if (pop) begin
            ent_done_p1[rd_ptr] <= 1'b0;
            rd_ptr              <= rd_ptr + PW'(1);
         end
         if (dok_drop)
            drop_cnt <= drop_cnt - CW'(1);
         if (dok_bad)
            err_q <= 1'b1;
         cnt      <= cnt + CW'(push_ok) - CW'(pop);
         pend_cnt <= pend_cnt + CW'(push_ok) - CW'(dok_fill);
      end
   end

   // Stage p1: entry payload, qualified by the control flags above
   always_ff @(posedge clk) begin
      if (push_ok && !q.flush) begin
         ent_op[wr_ptr]    <= q.req_op;
         ent_off[wr_ptr]   <= q.req_off;
         ent_store[wr_ptr] <= q.req_store;
      end
      if (dok_fill && !byp_pop && !q.flush)
         ent_data_p1[fill_idx] <= fill_val_p0;
   end
endmodule

// File: tb/tb_mem_resp_queue.sv
// Bench for mem_resp_queue: directed scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_mem_resp_queue;
   localparam int DEP0 = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, rst1;
   mem_resp_if #(.DATA_W(32)) b0 ();
   mem_resp_if #(.DATA_W(64)) b1 ();

   mem_resp_queue #(.DATA_W(32), .DEPTH(DEP0)) dut0 (.clk(clk), .reset(rst0), .q(b0));
   mem_resp_queue #(.DATA_W(64), .DEPTH(4))    dut1 (.clk(clk), .reset(rst1), .q(b1));

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [2:0]  op;
      logic        st;
      logic [1:0]  off;
      logic        done;
      logic [31:0] data;
   } ent_t;

   ent_t mq[$];
   int   mdrop;
   logic merr;

   logic        o_full, o_valid, o_store, o_err;
   logic [31:0] o_data;
   logic        o1_valid;
   logic [63:0] o1_data;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_ext(input logic [2:0] op, input int off, input logic [31:0] rd);
      logic [31:0] lane;
      lane = rd >> (off * 8);
      case (op)
         3'd0:    return {{24{lane[7]}}, lane[7:0]};
         3'd1:    return {{16{lane[15]}}, lane[15:0]};
         3'd4:    return {24'b0, lane[7:0]};
         3'd5:    return {16'b0, lane[15:0]};
         default: return lane;
      endcase
   endfunction

   function automatic int m_notdone();
      int n = 0;
      foreach (mq[i]) if (!mq[i].done) n++;
      return n;
   endfunction

   task automatic do_reset0();
      rst0 = 1'b1;
      b0.req_push = 0; b0.req_op = 0; b0.req_store = 0; b0.req_off = 0;
      b0.data_ok = 0; b0.rdata = 0; b0.flush = 0; b0.out_ready = 0;
      @(posedge clk); #1;
      chk("rst_full", b0.req_full, 0);
      chk("rst_valid", b0.out_valid, 0);
      chk("rst_data", b0.out_data, 0);
      chk("rst_store", b0.out_store, 0);
      chk("rst_err", b0.resp_err, 0);
      rst0 = 1'b0;
      mq.delete(); mdrop = 0; merr = 1'b0;
      @(posedge clk); #1;
   endtask

   // One DUT0 cycle: drive, compare against the model, advance the model, clock
   task automatic cyc(input logic push, input logic [2:0] op, input logic st, input logic [1:0] off,
                      input logic dok, input logic [31:0] rd, input logic fl, input logic rdy);
      int   nd, consumed;
      logic e_full, hd, byp, e_valid, e_store, pushed, found;
      logic [31:0] e_data;
      ent_t tmp;
      b0.req_push = push; b0.req_op = op; b0.req_store = st; b0.req_off = off;
      b0.data_ok = dok; b0.rdata = rd; b0.flush = fl; b0.out_ready = rdy;
      #2;
      o_full = b0.req_full; o_valid = b0.out_valid; o_data = b0.out_data;
      o_store = b0.out_store; o_err = b0.resp_err;
      nd     = m_notdone();
      e_full = (mq.size() + mdrop) == DEP0;
      hd     = (mq.size() > 0) && mq[0].done;
      byp    = 1'b0;
`ifdef MS_BYPASS_EN
      byp = !fl && dok && (mdrop == 0) && (mq.size() == 1) && !mq[0].done;
`endif
      e_valid = !fl && (hd || byp);
      e_data  = 0;
      if (e_valid) e_data = hd ? mq[0].data : (mq[0].st ? 32'd0 : ref_ext(mq[0].op, mq[0].off, rd));
      e_store = e_valid && mq[0].st;
      chk("m_full", o_full, e_full);
      chk("m_valid", o_valid, e_valid);
      chk("m_data", o_data, e_data);
      chk("m_store", o_store, e_store);
      chk("m_err", o_err, merr);
      pushed   = push && !e_full;
      consumed = 0;
      if (fl) begin
         if (dok) begin
            if (mdrop + nd == 0) merr = 1'b1;
            else consumed = 1;
         end
         mdrop = mdrop + nd + int'(pushed) - consumed;
         mq.delete();
      end else begin
         if (dok) begin
            if (mdrop > 0) mdrop--;
            else begin
               found = 1'b0;
               for (int i = 0; i < mq.size(); i++) begin
                  if (!found && !mq[i].done) begin
                     tmp = mq[i];
                     tmp.done = 1'b1;
                     tmp.data = tmp.st ? 32'd0 : ref_ext(tmp.op, tmp.off, rd);
                     mq[i] = tmp;
                     found = 1'b1;
                  end
               end
               if (!found) merr = 1'b1;
            end
         end
         if (e_valid && rdy) void'(mq.pop_front());
         if (pushed) begin
            tmp.op = op; tmp.st = st; tmp.off = off; tmp.done = 1'b0; tmp.data = 0;
            mq.push_back(tmp);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input logic rdy);
      cyc(0, 0, 0, 0, 0, 0, 0, rdy);
   endtask

   task automatic cyc1(input logic push, input logic [2:0] op, input logic [2:0] off,
                       input logic dok, input logic [63:0] rd, input logic rdy);
      b1.req_push = push; b1.req_op = op; b1.req_store = 0; b1.req_off = off;
      b1.data_ok = dok; b1.rdata = rd; b1.flush = 0; b1.out_ready = rdy;
      #2;
      o1_valid = b1.out_valid; o1_data = b1.out_data;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [2:0] ops [6];
      int pend;
      logic [2:0] rop;
      ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
      rst1 = 1'b1;
      b1.req_push = 0; b1.req_op = 0; b1.req_store = 0; b1.req_off = 0;
      b1.data_ok = 0; b1.rdata = 0; b1.flush = 0; b1.out_ready = 0;
      do_reset0();
      rst1 = 1'b0;

      // ld.b off=3 sign extension and result latency
      cyc(1, 3'd0, 0, 2'd3, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'h80FF_FF00, 0, 1);
`ifdef MS_BYPASS_EN
      chk("t1_byp_valid", o_valid, 1);
      chk("t1_byp_data", o_data, 32'hFFFF_FF80);
`else
      chk("t1_valid_early", o_valid, 0);
      idle(1);
      chk("t1_valid", o_valid, 1);
      chk("t1_data", o_data, 32'hFFFF_FF80);
`endif
      idle(1);
      chk("t1_after", o_valid, 0);

      // ld.hu + st.w held while WB stalls
      do_reset0();
      cyc(1, 3'd5, 0, 2'd2, 0, 0, 0, 0);
      cyc(1, 3'd2, 1, 2'd0, 0, 0, 0, 0);
      idle(0);
      chk("t2_full", o_full, 1);
      cyc(0, 0, 0, 0, 1, 32'h1234_0000, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'h5555_5555, 0, 0);
      idle(0);
      chk("t2_valid", o_valid, 1);
      chk("t2_data", o_data, 32'h0000_1234);
      chk("t2_store0", o_store, 0);
      idle(1);
      chk("t2_data_pop", o_data, 32'h0000_1234);
      idle(1);
      chk("t2_store1", o_store, 1);
      chk("t2_store_data", o_data, 0);
      idle(0);
      chk("t2_empty", o_valid, 0);
      chk("t2_notfull", o_full, 0);

      // flush with two loads outstanding
      do_reset0();
      cyc(1, 3'd2, 0, 2'd0, 0, 0, 0, 0);
      cyc(1, 3'd2, 0, 2'd0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 1);
      idle(1);
      chk("t3_full", o_full, 1);
      chk("t3_valid0", o_valid, 0);
      cyc(0, 0, 0, 0, 1, 32'h1111_1111, 0, 1);
      chk("t3_drop1_full", o_full, 1);
      chk("t3_drop1_valid", o_valid, 0);
      cyc(0, 0, 0, 0, 1, 32'h2222_2222, 0, 1);
      chk("t3_drop2_valid", o_valid, 0);
      idle(1);
      chk("t3_notfull", o_full, 0);
      chk("t3_err", o_err, 0);
      cyc(1, 3'd2, 0, 2'd0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'hCAFE_BABE, 0, 0);
      idle(1);
      chk("t3_new_valid", o_valid, 1);
      chk("t3_new_data", o_data, 32'hCAFE_BABE);
      idle(0);

      // flush together with push and data_ok, one pending
      do_reset0();
      cyc(1, 3'd0, 0, 2'd0, 0, 0, 0, 0);
      cyc(1, 3'd0, 0, 2'd0, 1, 32'h0000_00AA, 1, 0);
      idle(0);
      chk("t4_notfull", o_full, 0);
      cyc(1, 3'd4, 0, 2'd0, 0, 0, 0, 0);
      idle(0);
      chk("t4_drop1_full", o_full, 1);
      cyc(0, 0, 0, 0, 1, 32'h0000_00FF, 0, 0);
      idle(0);
      chk("t4_dropped_valid", o_valid, 0);
      chk("t4_dropped_full", o_full, 0);
      cyc(0, 0, 0, 0, 1, 32'h0000_00C3, 0, 0);
      idle(1);
      chk("t4_valid", o_valid, 1);
      chk("t4_data", o_data, 32'h0000_00C3);
      idle(0);

      // random traffic; responses only when the bus owes one
      for (int n = 0; n < 400; n++) begin
         pend = mdrop + m_notdone();
         rop  = ops[$urandom_range(0, 5)];
         cyc($urandom_range(0, 1) == 1, rop, $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
             (pend > 0) && ($urandom_range(0, 1) == 1), $urandom, $urandom_range(0, 15) == 0,
             $urandom_range(0, 2) != 0);
      end
      chk("rnd_err", o_err, 0);

      // spurious response sets a sticky error
      do_reset0();
      cyc(0, 0, 0, 0, 1, 32'h0, 0, 0);
      idle(0);
      chk("t5_err", o_err, 1);
      for (int n = 0; n < 3; n++) idle(1);
      chk("t5_err_sticky", o_err, 1);
      do_reset0();
      idle(0);
      chk("t5_err_cleared", o_err, 0);

      // 64-bit lanes
      cyc1(1, 3'd6, 3'd4, 0, 0, 0);
      cyc1(0, 0, 0, 1, 64'hDEAD_BEEF_0000_0000, 0);
      cyc1(0, 0, 0, 0, 0, 1);
      chk("t6_wu_valid", o1_valid, 1);
      chk("t6_wu_data", o1_data, 64'h0000_0000_DEAD_BEEF);
      cyc1(1, 3'd3, 3'd0, 0, 0, 0);
      cyc1(0, 0, 0, 1, 64'h0123_4567_89AB_CDEF, 0);
      cyc1(0, 0, 0, 0, 0, 1);
      chk("t6_d_data", o1_data, 64'h0123_4567_89AB_CDEF);
      cyc1(1, 3'd2, 3'd4, 0, 0, 0);
      cyc1(0, 0, 0, 1, 64'h8000_0000_0000_0000, 0);
      cyc1(0, 0, 0, 0, 0, 1);
      chk("t6_w_data", o1_data, 64'hFFFF_FFFF_8000_0000);
      cyc1(0, 0, 0, 0, 0, 1);
      chk("t6_empty", o1_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
